// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the two-stage RV32I core.
//   DATA_W       : datapath width (32)
//   OPC_*        : major opcode values
//   F3_* / F7_*  : funct3 / funct7 field values (ALU and branch)
//   alu_op_e     : ALU operation selected by the decoder
//   imm_fmt_e    : immediate encoding format
//   opa_sel_e    : ALU operand-A source
//   ctrl_t       : decoded control bundle handed from decoder to core
//   imm_gen()    : sign-extending immediate extraction
package rv32i_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;

  typedef struct packed {
    logic       reg_we;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       opb_imm;
    opa_sel_e   opa_sel;
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  function automatic logic signed [DATA_W-1:0] imm_gen(input logic [31:0] i,
                                                       input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_gen = {i[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder -- combinational instruction decode.
//   inst : instruction word currently in Execute
//   ctrl : control bundle (write enable, ALU op, operand selects, flow type)
//   imm  : sign-extended immediate for the instruction's format
// Opcodes outside the supported set decode to a NOP (no write, no redirect).
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic        [31:0]       inst,
  output ctrl_t                    ctrl,
  output logic signed [DATA_W-1:0] imm
);

  logic [31:0] rInstrustion;
  imm_fmt_e    imm_fmt;
  logic        alt;

  assign rInstrustion = inst;
  assign alt          = (rInstrustion[31:25] == F7_ALT);
  assign imm          = imm_gen(rInstrustion, imm_fmt);

  always_comb begin
    ctrl           = '0;
    ctrl.opa_sel   = OPA_RS1;
    ctrl.alu_op    = ALU_ADD;
    ctrl.funct3    = rInstrustion[14:12];
    ctrl.rd        = rInstrustion[11:7];
    ctrl.rs1       = rInstrustion[19:15];
    ctrl.rs2       = rInstrustion[24:20];
    imm_fmt        = IMM_I;
    case (rInstrustion[6:0])
      OPC_LUI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.opa_sel = OPA_ZERO;
        ctrl.opb_imm = 1'b1;
        imm_fmt      = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_we  = 1'b1;
        ctrl.opa_sel = OPA_PC;
        ctrl.opb_imm = 1'b1;
        imm_fmt      = IMM_U;
      end
      OPC_JAL: begin
        ctrl.reg_we = 1'b1;
        ctrl.is_jal = 1'b1;
        imm_fmt     = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_we  = 1'b1;
        ctrl.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        imm_fmt        = IMM_B;
      end
      OPC_OP_IMM, OPC_OP: begin
        ctrl.reg_we  = 1'b1;
        ctrl.opb_imm = (rInstrustion[6:0] == OPC_OP_IMM);
        case (rInstrustion[14:12])
          // SUB only exists in the register form; ADDI ignores bit 30
          F3_ADD_SUB: ctrl.alu_op = (alt && !ctrl.opb_imm) ? ALU_SUB : ALU_ADD;
          F3_SLL:     ctrl.alu_op = ALU_SLL;
          F3_SLT:     ctrl.alu_op = ALU_SLT;
          F3_SLTU:    ctrl.alu_op = ALU_SLTU;
          F3_XOR:     ctrl.alu_op = ALU_XOR;
          F3_SR:      ctrl.alu_op = alt ? ALU_SRA : ALU_SRL;
          F3_OR:      ctrl.alu_op = ALU_OR;
          default:    ctrl.alu_op = ALU_AND;
        endcase
      end
      default: ;  // LOAD, STORE, FENCE, SYSTEM, undefined: NOP
    endcase
  end

endmodule

// File: rtl/rv32i_core.sv
// rv32i_core -- two-stage (Fetch / Execute) RV32I integer core.
//   clk      : rising-edge clock
//   rstB     : asynchronous active-low reset (pc, valid flag, registers)
//   clkEn    : global clock enable; 0 freezes all state
//   pc       : fetch address presented to the synchronous program memory
//   inst_in  : instruction returned one cycle after pc was presented
//   dbg_addr : register index to observe      (RV32I_CORE_DBG_EN only)
//   dbg_data : value of that register, x0 = 0 (RV32I_CORE_DBG_EN only)
// Optional debug read port is built only when RV32I_CORE_DBG_EN is defined.
// Loads, stores, fence and system instructions execute as NOPs.
module rv32i_core
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rstB,
  input  logic              clkEn,
  output logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] inst_in
`ifdef RV32I_CORE_DBG_EN
  ,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  ctrl_t                    ctrl;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] rf [1:31];
  logic signed [DATA_W-1:0] rs1_val, rs2_val, op_a, op_b, alu_res, wb_data;
  logic        [DATA_W-1:0] pc_ex_p1, link_addr, br_target, jalr_target, pc_next;
  logic                     vld_p1, taken, redirect, rf_we;

  function automatic logic signed [DATA_W-1:0] alu(input alu_op_e op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_SUB:  alu = a - b;
      ALU_SLL:  alu = a << sh;
      ALU_SLT:  alu = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLTU: alu = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      ALU_XOR:  alu = a ^ b;
      ALU_SRL:  alu = $signed($unsigned(a) >> sh);
      ALU_SRA:  alu = a >>> sh;
      ALU_OR:   alu = a | b;
      ALU_AND:  alu = a & b;
      default:  alu = a + b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b);
    case (f3)
      F3_BEQ:  br_taken = (a == b);
      F3_BNE:  br_taken = (a != b);
      F3_BLT:  br_taken = (a < b);
      F3_BGE:  br_taken = (a >= b);
      F3_BLTU: br_taken = ($unsigned(a) < $unsigned(b));
      F3_BGEU: br_taken = ($unsigned(a) >= $unsigned(b));
      default: br_taken = 1'b0;
    endcase
  endfunction

  rv32i_decoder dec (
    .inst (inst_in),
    .ctrl (ctrl),
    .imm  (imm)
  );

  // Execute (p1): operands, ALU, branch resolution, next pc
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (ctrl.rs1 != 5'd0) rs1_val = rf[ctrl.rs1];
    if (ctrl.rs2 != 5'd0) rs2_val = rf[ctrl.rs2];
    case (ctrl.opa_sel)
      OPA_PC:   op_a = $signed(pc_ex_p1);
      OPA_ZERO: op_a = '0;
      default:  op_a = rs1_val;
    endcase
    op_b        = ctrl.opb_imm ? imm : rs2_val;
    alu_res     = alu(ctrl.alu_op, op_a, op_b);
    link_addr   = pc_ex_p1 + DATA_W'(4);
    br_target   = pc_ex_p1 + $unsigned(imm);
    jalr_target = $unsigned(rs1_val + imm) & ~DATA_W'(3);
    taken       = br_taken(ctrl.funct3, rs1_val, rs2_val);
    // Only a valid Execute may redirect; the squashed slot has no effects
    redirect    = vld_p1 & (ctrl.is_jal | ctrl.is_jalr | (ctrl.is_branch & taken));
    if (!redirect)        pc_next = pc + DATA_W'(4);
    else if (ctrl.is_jalr) pc_next = jalr_target;
    else                  pc_next = br_target;
    wb_data     = (ctrl.is_jal | ctrl.is_jalr) ? $signed(link_addr) : alu_res;
    rf_we       = clkEn & vld_p1 & ctrl.reg_we & (ctrl.rd != 5'd0);
  end

  // Fetch (p0) -> Execute (p1): pc and valid flag
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      pc     <= '0;
      vld_p1 <= 1'b0;
    end else if (clkEn) begin
      pc     <= pc_next;
      vld_p1 <= ~redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (clkEn) pc_ex_p1 <= pc;
  end

  // Execute (p1) writeback: register file, cleared by reset
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[ctrl.rd] <= wb_data;
    end
  end

`ifdef RV32I_CORE_DBG_EN
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : $unsigned(rf[dbg_addr]);
`endif

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core -- scoreboard bench for rv32i_core.
// A directed program runs from a small synchronous program memory model.
// The stimulus process pushes the expected pc after every edge and the
// expected register contents at checkpoints; a monitor process pops and
// compares on the falling edge.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rstB;
  logic        clkEn;
  logic [31:0] pc;
  logic [31:0] inst_in = 32'h0;
`ifdef RV32I_CORE_DBG_EN
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`endif

  always #5 clk = ~clk;

  rv32i_core dut (
    .clk     (clk),
    .rstB    (rstB),
    .clkEn   (clkEn),
    .pc      (pc),
    .inst_in (inst_in)
`ifdef RV32I_CORE_DBG_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`endif
  );

  // Program memory: one-cycle synchronous read, enabled with the core
  logic [31:0] mem [0:63];
  always @(posedge clk) if (clkEn) inst_in <= mem[pc[7:2]];

  typedef struct {
    int          idx;
    logic [31:0] val;
  } reg_exp_t;

  logic [31:0] pc_q [$];
  reg_exp_t    reg_q [$];
  int          n_run  = 0;
  int          n_fail = 0;

  // Expected pc after each edge following reset release; steps 2..4 disabled
  logic [31:0] pc_tab [0:30] = '{
    32'h04, 32'h08, 32'h08, 32'h08, 32'h08, 32'h0C, 32'h10, 32'h14,
    32'h18, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h34, 32'h24, 32'h28,
    32'h2C, 32'h30, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54,
    32'h58, 32'h5C, 32'h60, 32'h64, 32'h60, 32'h64, 32'h60};

  // Monitor / scoreboard
  logic [31:0] mon_exp, mon_got;
  reg_exp_t    mon_e;
  always @(negedge clk) begin
    if (pc_q.size() > 0) begin
      mon_exp = pc_q.pop_front();
      n_run++;
      if (pc !== mon_exp) begin
        n_fail++;
        $display("FAIL pc: got %08h expected %08h at %0t", pc, mon_exp, $time);
      end
    end
    while (reg_q.size() > 0) begin
      mon_e   = reg_q.pop_front();
      mon_got = dut.rf[mon_e.idx];
      n_run++;
      if (mon_got !== mon_e.val) begin
        n_fail++;
        $display("FAIL x%0d: got %08h expected %08h at %0t",
                 mon_e.idx, mon_got, mon_e.val, $time);
      end
`ifdef RV32I_CORE_DBG_EN
      n_run++;
      if (dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL dbg_x0: got %08h expected 00000000", dbg_data);
      end
`endif
    end
  end

  task automatic exp_reg(input int idx, input logic [31:0] val);
    reg_exp_t e;
    e.idx = idx;
    e.val = val;
    reg_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no summary expected one");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem['h00 >> 2] = 32'h00500093;  // addi x1,x0,5
    mem['h04 >> 2] = 32'hFFD08113;  // addi x2,x1,-3
    mem['h08 >> 2] = 32'h123451B7;  // lui  x3,0x12345
    mem['h0C >> 2] = 32'h00000013;  // nop
    mem['h10 >> 2] = 32'h00108463;  // beq  x1,x1,+8
    mem['h14 >> 2] = 32'h00100213;  // addi x4,x0,1 (shadow)
    mem['h18 >> 2] = 32'h00002703;  // lw   x14,0(x0) -> nop
    mem['h1C >> 2] = 32'h00102023;  // sw   x1,0(x0)  -> nop
    mem['h20 >> 2] = 32'h010002EF;  // jal  x5,+16
    mem['h24 >> 2] = 32'h00700013;  // addi x0,x0,7
    mem['h28 >> 2] = 32'h000003B3;  // add  x7,x0,x0
    mem['h2C >> 2] = 32'h0140006F;  // jal  x0,+20
    mem['h30 >> 2] = 32'h00028367;  // jalr x6,0(x5)
    mem['h40 >> 2] = 32'h40110433;  // sub  x8,x2,x1
    mem['h44 >> 2] = 32'h40145493;  // srai x9,x8,1
    mem['h48 >> 2] = 32'h0080B533;  // sltu x10,x1,x8
    mem['h4C >> 2] = 32'h001425B3;  // slt  x11,x8,x1
    mem['h50 >> 2] = 32'h00109463;  // bne  x1,x1,+8 (not taken)
    mem['h54 >> 2] = 32'h00144463;  // blt  x8,x1,+8
    mem['h58 >> 2] = 32'h00100613;  // addi x12,x0,1 (shadow)
    mem['h5C >> 2] = 32'h001456B3;  // srl  x13,x8,x1
    mem['h60 >> 2] = 32'h0000006F;  // jal  x0,0

    rstB  = 1'b0;
    clkEn = 1'b1;
    pc_q.push_back(32'h0);
    pc_q.push_back(32'h0);
    @(negedge clk);
    @(negedge clk);
    rstB = 1'b1;

    for (int i = 0; i < 31; i++) begin
      clkEn = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      pc_q.push_back(pc_tab[i]);
      @(negedge clk);
    end
    clkEn = 1'b1;

    exp_reg(1,  32'h00000005);
    exp_reg(2,  32'h00000002);
    exp_reg(3,  32'h12345000);
    exp_reg(4,  32'h00000000);
    exp_reg(5,  32'h00000024);
    exp_reg(6,  32'h00000034);
    exp_reg(7,  32'h00000000);
    exp_reg(8,  32'hFFFFFFFD);
    exp_reg(9,  32'hFFFFFFFE);
    exp_reg(10, 32'h00000001);
    exp_reg(11, 32'h00000001);
    exp_reg(12, 32'h00000000);
    exp_reg(13, 32'h07FFFFFF);
    exp_reg(14, 32'h00000000);
    repeat (2) @(negedge clk);

    // Mid-run asynchronous reset: pc and registers clear without a clock edge
    @(posedge clk);
    #2 rstB = 1'b0;
    pc_q.push_back(32'h0);
    exp_reg(1,  32'h0);
    exp_reg(6,  32'h0);
    exp_reg(13, 32'h0);
    @(negedge clk);
    #1 rstB = 1'b1;
    @(posedge clk);
    pc_q.push_back(32'h4);
    repeat (2) @(negedge clk);

    n_run++;
    if (pc_q.size() != 0 || reg_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", pc_q.size() + reg_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
